row_window_gen: RTL and testbench
=================================

Name: row_window_gen

Overview:
- Upstream feeder for the 3x3 convolution bank (8 parallel 3x3 kernels per window).
- Accepts a raster-order 8-bit pixel stream and keeps the two previous image lines internally.
- Emits three vertically aligned 80-bit row slices: 10 pixels each, leftmost pixel in bits [79:72].
- Windows advance by 8 columns, so consecutive windows overlap by 2 pixels and the 8 convolution results tile the output row exactly.

Parameters:
- IMG_W, 66, pixels per image line; must be >=10 and (IMG_W-2) divisible by 8; elaboration error otherwise.
- IMG_H, 64, lines per frame; must be >=3.
- PIX_W, 8, bits per pixel; fixed by the convolution bank.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_pixel valid this cycle; gaps allowed.
- in_sof  in  1  start of frame, qualified by in_valid; that pixel is (row 0, col 0).
- in_pixel  in  8  pixel value.
- img_R1  out  80  top row slice (line r-2).
- img_R2  out  80  middle row slice (line r-1).
- img_R3  out  80  bottom row slice (current line r).
- out_valid  out  1  one-cycle pulse; img_R* hold a complete window.
- out_row  out  $clog2(IMG_H)  output row index (r-2) of the window.
- out_col  out  $clog2(IMG_W)  leftmost output column (multiple of 8).

Behaviour:
- Reset: img_R1/2/3=0, out_valid=0, out_row=0, out_col=0; col/row counters=0; state=S_FILL. Line-buffer contents are not cleared.
- Per accepted pixel p at (r,c):
  - read lb1[c] (line r-1) and lb2[c] (line r-2);
  - write lb2[c]<=lb1[c], lb1[c]<=p.
- Internal shift registers, 80 bits each, shift left 8 and insert at the LSB byte: sh3 gets p, sh2 gets lb1[c], sh1 gets lb2[c].
- Window fires when r>=2, c>=9 and (c-9)%8==0.
  - Next cycle: img_R1..3 <= new sh1..3, out_valid=1, out_row=r-2, out_col=c-9.
  - Latency: 1 cycle from the accepting edge.
- img_R* hold their value between pulses.
- Counters:
  - c wraps IMG_W-1 -> 0 and increments r.
  - r wraps IMG_H-1 -> 0, which ends the frame.
- States:
  - S_FILL (r<2): no windows; moves to S_RUN on the edge that accepts pixel (1, IMG_W-1).
  - S_RUN: windows fire as above; returns to S_FILL on frame wrap or in_sof.
- in_sof with in_valid forces c=r=0 before processing, at any point including mid-frame.
  - Any window pending from the old frame is dropped.
  - State becomes S_FILL.
- in_valid=0: no counter, buffer or shift change; out_valid=0.
- Windows per frame: (IMG_H-2)*(IMG_W-2)/8.
- Shift registers are not cleared at line start; the first window of a line forms only after 10 fresh pixels, so no stale data reaches the output.

Optional Feature:
- Macro RWG_FRAME_DONE_EN.
- With it: extra output frame_done (1 bit, reset 0), pulsed together with out_valid for the last window of a frame (out_row=IMG_H-3, out_col=IMG_W-10).
- Without it: the port and its logic are absent.

Decomposition:
- Package cbs_pkg: PIX_W=8, WIN_PIX=10, STRIDE=8, ROW_BITS=80, KERNEL=3, and typedef pix_t (logic [7:0]).
- One sub-module, line_mem: single IMG_W x 8 line store, synchronous-write, combinational-read. Instantiate twice (lb1, lb2).

Test Plan:
All cases use IMG_W=18, IMG_H=4, pixel value = (r*18+c) mod 256, continuous in_valid, in_sof on the first pixel, unless stated otherwise.
- Window 1: after pixel (2,9) is accepted, next cycle out_valid=1, out_row=0, out_col=0, img_R1=0x00..0x09, img_R2=0x12..0x1B, img_R3=0x24..0x2D.
- Window 2: pixel (2,17) -> out_col=8, img_R3=0x2C..0x35, img_R1=0x08..0x11. Exactly 4 out_valid pulses per frame; with RWG_FRAME_DONE_EN, frame_done is coincident with the 4th pulse only.
- Gaps: random in_valid deassertion (about 50%) -> identical window contents and count; out_valid never asserts in a cycle not following an accepted pixel.
- Mid-frame in_sof at (1,5), then a full frame -> no window from the aborted frame; first window equals the Window 1 case.
- rst asserted asynchronously mid-line 2 -> outputs zero immediately without waiting for clk. A subsequent full frame produces the correct 4 windows.
- Frame wrap without in_sof: two back-to-back frames -> 8 pulses total, none during rows 0-1 of frame 2.

Source files
------------

// File: rtl/cbs_pkg.sv
// Shared constants and types for the 3x3 convolution bank front end.
package cbs_pkg;

  localparam int unsigned PIX_W    = 8;   // bits per pixel
  localparam int unsigned WIN_PIX  = 10;  // pixels per row slice
  localparam int unsigned STRIDE   = 8;   // column advance between windows
  localparam int unsigned ROW_BITS = 80;  // WIN_PIX * PIX_W
  localparam int unsigned KERNEL   = 3;   // kernel height/width

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } rwg_state_e;

endpackage

// File: rtl/row_window_gen_line_mem.sv
// line_mem: single image-line store, DEPTH x PIX_W.
// Synchronous write, combinational read; contents are never cleared.
// Ports: clk, we (write enable), addr (shared read/write column),
//        wdata (pixel to store), rdata (pixel currently held at addr).
module line_mem
  import cbs_pkg::*;
#(
  parameter int unsigned DEPTH = 66,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pix_t          wdata,
  output pix_t          rdata
);

  pix_t mem [DEPTH];

  // Storage only; no reset so it maps onto plain RAM/flop arrays.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/row_window_gen.sv
// row_window_gen: turns a raster pixel stream into 3-row x 10-pixel windows
// stepping 8 columns, for a bank of 8 parallel 3x3 kernels.
// Ports: clk, rst (async, active-high); in_valid/in_sof/in_pixel stream in;
//        img_R1/R2/R3 row slices (lines r-2, r-1, r; leftmost pixel in MSBs),
//        out_valid one-cycle window pulse, out_row/out_col window origin.
// Optional: define RWG_FRAME_DONE_EN to add frame_done, pulsed with the
//           last window of each frame.
module row_window_gen
  import cbs_pkg::*;
#(
  parameter int unsigned IMG_W = 66,
  parameter int unsigned IMG_H = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [PIX_W-1:0]         in_pixel,
  output logic [ROW_BITS-1:0]      img_R1,
  output logic [ROW_BITS-1:0]      img_R2,
  output logic [ROW_BITS-1:0]      img_R3,
`ifdef RWG_FRAME_DONE_EN
  output logic                     frame_done,
`endif
  output logic                     out_valid,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  if ((IMG_W < WIN_PIX) || (((IMG_W - 2) % STRIDE) != 0) || (IMG_H < KERNEL)) begin : g_param_err
    $error("row_window_gen: IMG_W must be >=10 with (IMG_W-2)%%8==0, IMG_H >=3");
  end

  rwg_state_e          state_q, state_d, state_cur;
  logic [CW-1:0]       col_q, col_d, col_cur;
  logic [RW-1:0]       row_q, row_d, row_cur;
  logic [ROW_BITS-1:0] sh1_q, sh1_d, sh2_q, sh2_d, sh3_q, sh3_d;
  logic [ROW_BITS-1:0] img_r1_q, img_r1_d, img_r2_q, img_r2_d, img_r3_q, img_r3_d;
  logic                out_valid_q, out_valid_d;
  logic [RW-1:0]       out_row_q, out_row_d;
  logic [CW-1:0]       out_col_q, out_col_d;
  logic                last_col, last_row, fire;
  pix_t                lb1_rd, lb2_rd;

  // Start-of-frame restarts the raster position before the pixel is used.
  always_comb begin
    col_cur   = col_q;
    row_cur   = row_q;
    state_cur = state_q;
    if (in_valid && in_sof) begin
      col_cur   = '0;
      row_cur   = '0;
      state_cur = S_FILL;
    end
  end

  // lb1 holds line r-1, lb2 holds line r-2; each pixel ages one line down.
  line_mem #(.DEPTH(IMG_W)) u_lb1 (
    .clk   (clk),
    .we    (in_valid),
    .addr  (col_cur),
    .wdata (in_pixel),
    .rdata (lb1_rd)
  );

  line_mem #(.DEPTH(IMG_W)) u_lb2 (
    .clk   (clk),
    .we    (in_valid),
    .addr  (col_cur),
    .wdata (lb1_rd),
    .rdata (lb2_rd)
  );

  // Next-state, shift and window-capture logic.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    sh1_d       = sh1_q;
    sh2_d       = sh2_q;
    sh3_d       = sh3_q;
    img_r1_d    = img_r1_q;
    img_r2_d    = img_r2_q;
    img_r3_d    = img_r3_q;
    out_valid_d = 1'b0;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    last_col    = (col_cur == CW'(IMG_W - 1));
    last_row    = (row_cur == RW'(IMG_H - 1));
    // Window completes when the pixel just taken is the 10th of an 8-stepped slice.
    fire        = in_valid && (state_cur == S_RUN) &&
                  (col_cur >= CW'(WIN_PIX - 1)) &&
                  (((col_cur - CW'(WIN_PIX - 1)) % CW'(STRIDE)) == '0);

    if (in_valid) begin
      state_d = state_cur;
      sh3_d   = {sh3_q[ROW_BITS-PIX_W-1:0], in_pixel};
      sh2_d   = {sh2_q[ROW_BITS-PIX_W-1:0], lb1_rd};
      sh1_d   = {sh1_q[ROW_BITS-PIX_W-1:0], lb2_rd};

      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end

      // Two full lines buffered once row KERNEL-2 completes.
      if ((state_cur == S_FILL) && last_col && (row_cur == RW'(KERNEL - 2)))
        state_d = S_RUN;
      if ((state_cur == S_RUN) && last_col && last_row)
        state_d = S_FILL;

      if (fire) begin
        img_r1_d    = sh1_d;
        img_r2_d    = sh2_d;
        img_r3_d    = sh3_d;
        out_valid_d = 1'b1;
        out_row_d   = row_cur - RW'(KERNEL - 1);
        out_col_d   = col_cur - CW'(WIN_PIX - 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      col_q       <= '0;
      row_q       <= '0;
      sh1_q       <= '0;
      sh2_q       <= '0;
      sh3_q       <= '0;
      img_r1_q    <= '0;
      img_r2_q    <= '0;
      img_r3_q    <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
      sh3_q       <= sh3_d;
      img_r1_q    <= img_r1_d;
      img_r2_q    <= img_r2_d;
      img_r3_q    <= img_r3_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  assign img_R1    = img_r1_q;
  assign img_R2    = img_r2_q;
  assign img_R3    = img_r3_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;

`ifdef RWG_FRAME_DONE_EN
  logic frame_done_q, frame_done_d;

  // Last window of the frame: bottom row, rightmost slice.
  always_comb begin
    frame_done_d = fire && last_row && last_col;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_done_q <= 1'b0;
    else     frame_done_q <= frame_done_d;
  end

  assign frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_row_window_gen.sv
// Directed bench for row_window_gen with an 18x4 image, pixel = r*18+c.
module tb_row_window_gen;

  localparam int unsigned W = 18;
  localparam int unsigned H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [7:0]  in_pixel = '0;
  logic [79:0] img_R1, img_R2, img_R3;
  logic        out_valid;
  logic [1:0]  out_row;
  logic [4:0]  out_col;
`ifdef RWG_FRAME_DONE_EN
  logic        frame_done;
`endif

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  row_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
    .img_R1    (img_R1),
    .img_R2    (img_R2),
    .img_R3    (img_R3),
`ifdef RWG_FRAME_DONE_EN
    .frame_done(frame_done),
`endif
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_col   (out_col)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] slice(input int r, input int c0);
    logic [79:0] s;
    s = '0;
    for (int k = 0; k < 10; k++) s = {s[71:0], 8'((r * W + c0 + k) % 256)};
    return s;
  endfunction

  task automatic idle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = 8'($urandom);
    @(posedge clk); #1;
    check("idle_valid", 80'(out_valid), 80'(0));
  endtask

  task automatic send(input int r, input int c, input logic sof);
    logic exp_v;
    int   orow, ocol;
    in_valid = 1'b1;
    in_sof   = sof;
    in_pixel = 8'((r * W + c) % 256);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    exp_v = (r >= 2) && (c >= 9) && (((c - 9) % 8) == 0);
    check("out_valid", 80'(out_valid), 80'(exp_v));
`ifdef RWG_FRAME_DONE_EN
    check("frame_done", 80'(frame_done), 80'(exp_v && (r == H - 1) && (c == W - 1)));
`endif
    if (exp_v) begin
      orow = r - 2;
      ocol = c - 9;
      pulses++;
      check("out_row", 80'(out_row), 80'(orow));
      check("out_col", 80'(out_col), 80'(ocol));
      check("img_R1", img_R1, slice(orow, ocol));
      check("img_R2", img_R2, slice(orow + 1, ocol));
      check("img_R3", img_R3, slice(orow + 2, ocol));
      if (orow == 0 && ocol == 0) begin
        check("win1_R1", img_R1, 80'h00010203040506070809);
        check("win1_R2", img_R2, 80'h12131415161718191a1b);
        check("win1_R3", img_R3, 80'h2425262728292a2b2c2d);
      end
      if (orow == 0 && ocol == 8) begin
        check("win2_R1", img_R1, 80'h08090a0b0c0d0e0f1011);
        check("win2_R3", img_R3, 80'h2c2d2e2f303132333435);
      end
    end
  endtask

  // Sends raster pixels from (0,0) through (stop_r, stop_c) inclusive.
  task automatic frame(input logic first_sof, input logic gaps, input int stop_r, input int stop_c);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r * W + c <= stop_r * W + stop_c) begin
          if (gaps) repeat ($urandom_range(0, 2)) idle();
          send(r, c, first_sof && (r == 0) && (c == 0));
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_R1"}, img_R1, '0);
    check({tag, "_R2"}, img_R2, '0);
    check({tag, "_R3"}, img_R3, '0);
    check({tag, "_valid"}, 80'(out_valid), 80'(0));
    check({tag, "_row"}, 80'(out_row), 80'(0));
    check({tag, "_col"}, 80'(out_col), 80'(0));
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 check_zero("reset");
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;

    // Continuous frame.
    pulses = 0;
    frame(1'b1, 1'b0, H - 1, W - 1);
    check("pulses_frame", 80'(pulses), 80'(4));
    idle();

    // Random input gaps.
    pulses = 0;
    frame(1'b1, 1'b1, H - 1, W - 1);
    check("pulses_gaps", 80'(pulses), 80'(4));

    // Abort at (1,5) with a new start of frame.
    pulses = 0;
    frame(1'b1, 1'b0, 1, 5);
    frame(1'b1, 1'b0, H - 1, W - 1);
    check("pulses_abort", 80'(pulses), 80'(4));

    // Asynchronous reset in line 2 after window 2 is showing.
    frame(1'b1, 1'b0, 2, 17);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(posedge clk); #3;
    rst = 1'b0;
    pulses = 0;
    frame(1'b1, 1'b0, H - 1, W - 1);
    check("pulses_after_rst", 80'(pulses), 80'(4));

    // Back-to-back frames, second one without in_sof.
    pulses = 0;
    frame(1'b1, 1'b0, H - 1, W - 1);
    frame(1'b0, 1'b0, H - 1, W - 1);
    check("pulses_wrap", 80'(pulses), 80'(8));
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
